pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl_if.sv | 38 +++
 rtl/pipe_hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX hazard inputs, stage control outputs
// and the status/performance readback.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_br_taken;
    logic             ex_mc_start;
    logic             mc_done;
    logic             pc_hold;
    logic             if_id_hold;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_hold;
    logic             mc_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             ctrl_state;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd,
               ex_mem_read, ex_br_taken, ex_mc_start, mc_done,
        input  pc_hold, if_id_hold, if_id_flush, id_ex_flush, ex_hold,
               mc_timeout, stall_cnt, flush_cnt, ctrl_state
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd,
               ex_mem_read, ex_br_taken, ex_mc_start, mc_done,
        output pc_hold, if_id_hold, if_id_flush, id_ex_flush, ex_hold,
               mc_timeout, stall_cnt, flush_cnt, ctrl_state
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer for the IF/ID and ID/EX stage registers.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   RUN     | normal issue; branch flush, mul/div entry, load-use bubble
//   MC_WAIT | front end and EX frozen until mc_done or the watchdog fires
//
// Control outputs are combinational from state and inputs (no latency)
// and are forced low while rst is asserted.
module pipe_hazard_ctrl #(
    parameter int CNT_W      = 32,
    parameter int MC_TIMEOUT = 64
) (
    input logic                clk,
    input logic                rst,
    pipe_hazard_ctrl_if.slave  bus
);

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    // Timer value seen in the last MC_WAIT cycle before the watchdog fires.
    localparam logic [15:0] TIMER_LAST = 16'(MC_TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [15:0]      timer, timer_nxt;
    logic             mc_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    logic load_use;
    logic pc_hold_c, if_id_hold_c, if_id_flush_c, id_ex_flush_c, ex_hold_c;
    logic br_event, timeout_set;

    // Load in EX whose destination feeds a source the ID instruction reads.
    always_comb begin
        load_use = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                   ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                    (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd)));
    end

    // Next-state and stage-control decode.
    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer;
        pc_hold_c     = 1'b0;
        if_id_hold_c  = 1'b0;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;
        ex_hold_c     = 1'b0;
        br_event      = 1'b0;
        timeout_set   = 1'b0;
        case (state)
            RUN: begin
                if (bus.ex_br_taken) begin
                    // Redirect wins: the younger instructions are squashed, so
                    // any mul/div or load-use they would trigger is moot.
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                    br_event      = 1'b1;
                end else if (bus.ex_mc_start) begin
                    pc_hold_c    = 1'b1;
                    if_id_hold_c = 1'b1;
                    ex_hold_c    = 1'b1;
                    state_nxt    = MC_WAIT;
                    timer_nxt    = 16'd0;
                end else if (load_use) begin
                    pc_hold_c     = 1'b1;
                    if_id_hold_c  = 1'b1;
                    id_ex_flush_c = 1'b1;
                end
            end
            MC_WAIT: begin
                if (bus.mc_done) begin
                    // Completion takes precedence over a coincident watchdog.
                    state_nxt = RUN;
                end else if (timer == TIMER_LAST) begin
                    timeout_set = 1'b1;
                    state_nxt   = RUN;
                end else begin
                    pc_hold_c    = 1'b1;
                    if_id_hold_c = 1'b1;
                    ex_hold_c    = 1'b1;
                    timer_nxt    = timer + 16'd1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // FSM state and multi-cycle watchdog timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            timer <= 16'd0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    // Sticky watchdog flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              mc_timeout <= 1'b0;
        else if (timeout_set) mc_timeout <= 1'b1;
    end

    // Saturating stall and branch-flush performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_hold_c && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (br_event && (flush_cnt != '1))  flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign bus.pc_hold     = pc_hold_c     & ~rst;
    assign bus.if_id_hold  = if_id_hold_c  & ~rst;
    assign bus.if_id_flush = if_id_flush_c & ~rst;
    assign bus.id_ex_flush = id_ex_flush_c & ~rst;
    assign bus.ex_hold     = ex_hold_c     & ~rst;
    assign bus.mc_timeout  = mc_timeout;
    assign bus.stall_cnt   = stall_cnt;
    assign bus.flush_cnt   = flush_cnt;
    assign bus.ctrl_state  = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl with a narrow counter and a
// short watchdog so saturation and timeout are reachable quickly.
module tb_pipe_hazard_ctrl;

    localparam int CW = 4;
    localparam int TO = 8;
    localparam int SAT = (1 << CW) - 1;

    typedef struct packed {
        logic          pc_hold;
        logic          if_id_hold;
        logic          if_id_flush;
        logic          id_ex_flush;
        logic          ex_hold;
        logic          mc_timeout;
        logic          ctrl_state;
        logic [CW-1:0] stall_cnt;
        logic [CW-1:0] flush_cnt;
    } obs_t;

    logic clk;
    logic rst;
    pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

    pipe_hazard_ctrl #(.CNT_W(CW), .MC_TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    obs_t sb[$];

    // Reference model state.
    int m_state, m_timer, m_to, m_stall, m_flush;

    function automatic obs_t observe();
        obs_t o;
        o.pc_hold     = bus.pc_hold;
        o.if_id_hold  = bus.if_id_hold;
        o.if_id_flush = bus.if_id_flush;
        o.id_ex_flush = bus.id_ex_flush;
        o.ex_hold     = bus.ex_hold;
        o.mc_timeout  = bus.mc_timeout;
        o.ctrl_state  = bus.ctrl_state;
        o.stall_cnt   = bus.stall_cnt;
        o.flush_cnt   = bus.flush_cnt;
        return o;
    endfunction

    task automatic model_clear();
        m_state = 0; m_timer = 0; m_to = 0; m_stall = 0; m_flush = 0;
        sb.delete();
    endtask

    task automatic set_idle();
        bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0;
        bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0;
        bus.ex_rd = 5'd0; bus.ex_mem_read = 1'b0;
        bus.ex_br_taken = 1'b0; bus.ex_mc_start = 1'b0; bus.mc_done = 1'b0;
    endtask

    // One clock of stimulus: drive, push the model's expectation, advance
    // the model, and return at the following negedge ready for sampling.
    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic mr, input logic br, input logic mc,
                         input logic done);
        obs_t e;
        logic lu;
        @(posedge clk);
        #1;
        bus.id_rs1 = rs1; bus.id_rs2 = rs2;
        bus.id_uses_rs1 = u1; bus.id_uses_rs2 = u2;
        bus.ex_rd = rd; bus.ex_mem_read = mr;
        bus.ex_br_taken = br; bus.ex_mc_start = mc; bus.mc_done = done;
        lu = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        e = '0;
        e.mc_timeout = 1'(m_to);
        e.ctrl_state = 1'(m_state);
        e.stall_cnt  = CW'(m_stall);
        e.flush_cnt  = CW'(m_flush);
        if (m_state == 0) begin
            if (br) begin
                e.if_id_flush = 1; e.id_ex_flush = 1;
                if (m_flush < SAT) m_flush++;
            end else if (mc) begin
                e.pc_hold = 1; e.if_id_hold = 1; e.ex_hold = 1;
                m_state = 1; m_timer = 0;
            end else if (lu) begin
                e.pc_hold = 1; e.if_id_hold = 1; e.id_ex_flush = 1;
            end
        end else begin
            if (done) m_state = 0;
            else if (m_timer == TO - 1) begin m_to = 1; m_state = 0; end
            else begin
                e.pc_hold = 1; e.if_id_hold = 1; e.ex_hold = 1;
                m_timer++;
            end
        end
        if (e.pc_hold && m_stall < SAT) m_stall++;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        set_idle();
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        obs_t g, e;
        rst = 1'b1;
        set_idle();
        bus.ex_mc_start = 1'b1;
        bus.ex_br_taken = 1'b1;
        model_clear();
        #2;
        g = observe();
        total++;
        if (g !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", g); end
        @(negedge clk);
        rst = 1'b0;
        set_idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        e = sb.pop_front(); g = observe(); total++;
        if (g !== e) begin bad++; $display("FAIL reset_idle got=%h exp=%h", g, e); end
    endtask

    task automatic test_load_use();
        obs_t g, e;
        apply_reset();
        drive(5, 1, 1, 1, 5, 1, 0, 0, 0);
        e = sb.pop_front(); g = observe(); total++;
        if (g !== e) begin bad++; $display("FAIL load_use_stall got=%h exp=%h", g, e); end
        total++;
        if ({g.pc_hold, g.if_id_hold, g.id_ex_flush, g.ex_hold} !== 4'b1110) begin
            bad++; $display("FAIL load_use_ctl got=%b exp=1110",
                            {g.pc_hold, g.if_id_hold, g.id_ex_flush, g.ex_hold});
        end
        drive(6, 1, 1, 1, 6, 0, 0, 0, 0);
        e = sb.pop_front(); g = observe(); total++;
        if (g !== e) begin bad++; $display("FAIL load_use_clear got=%h exp=%h", g, e); end
        total++;
        if (g.stall_cnt !== 4'd1) begin bad++; $display("FAIL load_use_cnt got=%0d exp=1", g.stall_cnt); end
        // rs2 match with rs2 used must also stall.
        drive(0, 9, 0, 1, 9, 1, 0, 0, 0);
        e = sb.pop_front(); g = observe(); total++;
        if (g !== e) begin bad++; $display("FAIL load_use_rs2 got=%h exp=%h", g, e); end
    endtask

    task automatic test_branch_priority();
        obs_t g, e;
        apply_reset();
        drive(5, 0, 1, 0, 5, 1, 1, 0, 0);
        e = sb.pop_front(); g = observe(); total++;
        if (g !== e) begin bad++; $display("FAIL br_over_lu got=%h exp=%h", g, e); end
        drive(3, 0, 1, 0, 3, 0, 1, 1, 0);
        e = sb.pop_front(); g = observe(); total++;
        if (g !== e) begin bad++; $display("FAIL br_over_mc got=%h exp=%h", g, e); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        e = sb.pop_front(); g = observe(); total++;
        if (g !== e) begin bad++; $display("FAIL br_after got=%h exp=%h", g, e); end
        total++;
        if (g.flush_cnt !== 4'd2 || g.stall_cnt !== 4'd0 || g.ctrl_state !== 1'b0) begin
            bad++; $display("FAIL br_counts got=%0d/%0d/%0d exp=2/0/0",
                            g.flush_cnt, g.stall_cnt, g.ctrl_state);
        end
    endtask

    task automatic test_mc_done();
        obs_t g, e;
        int holds, waits;
        apply_reset();
        holds = 0; waits = 0;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, (i == 0), (i == 6));
            e = sb.pop_front(); g = observe(); total++;
            if (g !== e) begin bad++; $display("FAIL mc_done_cyc%0d got=%h exp=%h", i, g, e); end
            holds += int'(g.pc_hold && g.ex_hold);
            waits += int'(g.ctrl_state);
        end
        total++;
        if (holds != 6 || waits != 6 || g.stall_cnt !== 4'd6 || g.mc_timeout !== 1'b0) begin
            bad++; $display("FAIL mc_done_sum got=%0d/%0d/%0d/%0d exp=6/6/6/0",
                            holds, waits, g.stall_cnt, g.mc_timeout);
        end
    endtask

    task automatic test_timeout();
        obs_t g, e;
        int holds;
        apply_reset();
        holds = 0;
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, (i == 0), 0);
            e = sb.pop_front(); g = observe(); total++;
            if (g !== e) begin bad++; $display("FAIL timeout_cyc%0d got=%h exp=%h", i, g, e); end
            holds += int'(g.pc_hold);
        end
        total++;
        if (holds != 8 || g.mc_timeout !== 1'b1) begin
            bad++; $display("FAIL timeout_sum got=%0d/%0d exp=8/1", holds, g.mc_timeout);
        end
        for (int i = 0; i < 4; i++) begin
            drive(7, 0, 1, 0, 7, (i % 2 == 0), 0, 0, 0);
            e = sb.pop_front(); g = observe(); total++;
            if (g !== e) begin bad++; $display("FAIL timeout_after%0d got=%h exp=%h", i, g, e); end
        end
        total++;
        if (g.mc_timeout !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%0d exp=1", g.mc_timeout); end
    endtask

    task automatic test_done_at_timeout();
        obs_t g, e;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, (i == 0), (i == 8));
            e = sb.pop_front(); g = observe(); total++;
            if (g !== e) begin bad++; $display("FAIL done_at_to_cyc%0d got=%h exp=%h", i, g, e); end
        end
        total++;
        if (g.mc_timeout !== 1'b0 || g.stall_cnt !== 4'd8) begin
            bad++; $display("FAIL done_at_to got=%0d/%0d exp=0/8", g.mc_timeout, g.stall_cnt);
        end
    endtask

    task automatic test_rd_zero();
        obs_t g, e;
        apply_reset();
        drive(0, 0, 1, 0, 0, 1, 0, 0, 0);
        e = sb.pop_front(); g = observe(); total++;
        if (g !== e) begin bad++; $display("FAIL rd_zero got=%h exp=%h", g, e); end
        drive(1, 4, 1, 0, 4, 1, 0, 0, 0);
        e = sb.pop_front(); g = observe(); total++;
        if (g !== e) begin bad++; $display("FAIL rs2_unused got=%h exp=%h", g, e); end
        drive(4, 0, 0, 0, 4, 1, 0, 0, 0);
        e = sb.pop_front(); g = observe(); total++;
        if (g !== e) begin bad++; $display("FAIL rs1_unused got=%h exp=%h", g, e); end
        total++;
        if (g.pc_hold !== 1'b0 || g.stall_cnt !== 4'd0) begin
            bad++; $display("FAIL no_stall got=%0d/%0d exp=0/0", g.pc_hold, g.stall_cnt);
        end
    endtask

    task automatic test_async_reset();
        obs_t g, e;
        apply_reset();
        for (int i = 0; i < 14; i++) begin
            drive(0, 0, 0, 0, 0, 0, (i == 12), (i == 0 || i == 10), 0);
            e = sb.pop_front(); g = observe(); total++;
            if (g !== e) begin bad++; $display("FAIL pre_areset%0d got=%h exp=%h", i, g, e); end
        end
        total++;
        if (g.ctrl_state !== 1'b1 || g.mc_timeout !== 1'b1) begin
            bad++; $display("FAIL areset_setup got=%0d/%0d exp=1/1", g.ctrl_state, g.mc_timeout);
        end
        #1;
        rst = 1'b1;
        #1;
        g = observe(); total++;
        if (g !== '0) begin bad++; $display("FAIL areset_clear got=%h exp=0", g); end
        model_clear();
        #1;
        rst = 1'b0;
        set_idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        e = sb.pop_front(); g = observe(); total++;
        if (g !== e) begin bad++; $display("FAIL areset_after got=%h exp=%h", g, e); end
    endtask

    task automatic test_saturation();
        obs_t g, e;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            drive(2, 0, 1, 0, 2, 1, 0, 0, 0);
            e = sb.pop_front(); g = observe(); total++;
            if (g !== e) begin bad++; $display("FAIL sat_stall%0d got=%h exp=%h", i, g, e); end
        end
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
            e = sb.pop_front(); g = observe(); total++;
            if (g !== e) begin bad++; $display("FAIL sat_flush%0d got=%h exp=%h", i, g, e); end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        e = sb.pop_front(); g = observe(); total++;
        if (g.stall_cnt !== 4'd15 || g.flush_cnt !== 4'd15) begin
            bad++; $display("FAIL sat_final got=%0d/%0d exp=15/15", g.stall_cnt, g.flush_cnt);
        end
    endtask

    task automatic test_back_to_back();
        obs_t g, e;
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 9) == 0));
            e = sb.pop_front(); g = observe(); total++;
            if (g !== e) begin bad++; $display("FAIL random%0d got=%h exp=%h", i, g, e); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_load_use();
        test_branch_priority();
        test_mc_done();
        test_timeout();
        test_done_at_timeout();
        test_rd_zero();
        test_async_reset();
        test_saturation();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
